// File: rtl/sub_vector_checker.sv
// Self-test wrapper for a 32-bit subtractor: drives operand pairs, samples the result a cycle later,
// and reports mismatch count plus the first failing vector.
module sub_vector_checker #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_2023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] dut_diff,
    input  logic        dut_bout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx,
    output logic [31:0] first_fail_a,
    output logic [31:0] first_fail_b
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] lfsr;
    logic [15:0] idx;
    logic        launch, advance, compare;
    logic [15:0] nxt_idx;
    logic [31:0] nxt_a, nxt_b;
    logic [31:0] exp_diff;
    logic        exp_bout, mismatch;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'd0);
    endfunction

    // Directed corner operands for indices 0..3, packed as {a, b}.
    function automatic logic [63:0] corner_ops(input logic [1:0] i);
        case (i)
            2'd0:    return {32'h0000_0000, 32'h0000_0000};
            2'd1:    return {32'h0000_0000, 32'h0000_0001};
            2'd2:    return {32'hFFFF_FFFF, 32'h0000_0001};
            default: return {32'h8000_0000, 32'h0000_0001};
        endcase
    endfunction

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        advance    = 1'b0;
        compare    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = DRIVE;
                    launch     = 1'b1;
                end
            end
            DRIVE: state_next = SAMPLE;
            SAMPLE: begin
                compare = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                    advance    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        nxt_idx = idx + 16'd1;
        if (nxt_idx < 16'd4) begin
            {nxt_a, nxt_b} = corner_ops(nxt_idx[1:0]);
        end else begin
            nxt_a = lfsr;
            nxt_b = {lfsr[15:0], lfsr[31:16]};
        end
        exp_diff = op_a - op_b;
        exp_bout = (op_a < op_b);
        mismatch = (dut_diff != exp_diff) || (dut_bout != exp_bout);
    end

    // Restart reloads SEED so every run replays the same vector sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= SEED_EFF;
            idx            <= 16'd0;
            op_a           <= 32'd0;
            op_b           <= 32'd0;
            err_count      <= 16'd0;
            first_fail_idx <= 16'd0;
            first_fail_a   <= 32'd0;
            first_fail_b   <= 32'd0;
        end else begin
            state <= state_next;
            if (launch) begin
                lfsr           <= SEED_EFF;
                idx            <= 16'd0;
                op_a           <= 32'd0;
                op_b           <= 32'd0;
                err_count      <= 16'd0;
                first_fail_idx <= 16'd0;
                first_fail_a   <= 32'd0;
                first_fail_b   <= 32'd0;
            end
            if (compare && mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                // err_count saturates, so zero reliably marks "no failure yet this run".
                if (err_count == 16'd0) begin
                    first_fail_idx <= idx;
                    first_fail_a   <= op_a;
                    first_fail_b   <= op_b;
                end
            end
            if (advance) begin
                idx  <= nxt_idx;
                op_a <= nxt_a;
                op_b <= nxt_b;
                if (nxt_idx >= 16'd4) begin
                    lfsr <= lfsr_step(lfsr);
                end
            end
        end
    end

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0);

endmodule
